sw_debounce: RTL and testbench

Synchronous switch debouncer and load-pulse generator that sits directly upstream of the synchronous D flip-flop stage (DFF_sync). It synchronises a raw asynchronous switch input and accepts a level change only after the change has been stable for a programmable number of clock cycles. On each accepted change it drives the new level on DOUT together with a single-cycle LD strobe, so DOUT/LD connect straight to the flip-flop's D/LD inputs. RISE/FALL strobes and a BUSY flag are provided for status.

---
 rtl/sw_debounce_if.sv | 28 ++
 rtl/sw_debounce.sv | 94 +++++++++
 tb/tb_sw_debounce.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/sw_debounce_if.sv
// Switch-side bundle of the debouncer: raw switch in, debounced level and
// strobes out toward the downstream load flip-flop.
interface sw_debounce_if;
    logic SW;
    logic DOUT;
    logic LD;
    logic RISE;
    logic FALL;
    logic BUSY;

    modport master (
        output SW,
        input  DOUT,
        input  LD,
        input  RISE,
        input  FALL,
        input  BUSY
    );

    modport slave (
        input  SW,
        output DOUT,
        output LD,
        output RISE,
        output FALL,
        output BUSY
    );
endinterface

// File: rtl/sw_debounce.sv
// Switch debouncer: two-flop synchroniser, stability counter and a registered
// load/edge strobe issued on every accepted level change.
module sw_debounce #(
    parameter int DB_CYCLES = 4,
    parameter int CW        = 16
) (
    input logic           CK,
    input logic           RB,
    sw_debounce_if.slave  bus
);

    typedef enum logic {
        STABLE = 1'b0,
        COUNT  = 1'b1
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          s1, s2;
    logic          dout_q, dout_d;
    logic          ld_q, ld_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    // Stage boundary: synchroniser, counter, FSM state and strobe registers
    always_ff @(posedge CK) begin
        if (!RB) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            state_q <= STABLE;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            ld_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s1      <= bus.SW;
            s2      <= s1;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            ld_q    <= ld_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Strobes default low so each one lasts exactly the cycle after a commit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        ld_d    = 1'b0;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            STABLE: begin
                if (s2 != dout_q) begin
                    state_d = COUNT;
                    cnt_d   = CNT_ONE;
                end
            end
            COUNT: begin
                if (s2 == dout_q) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                    dout_d  = s2;
                    ld_d    = 1'b1;
                    rise_d  = s2;
                    fall_d  = ~s2;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.DOUT = dout_q;
    assign bus.LD   = ld_q;
    assign bus.RISE = rise_q;
    assign bus.FALL = fall_q;
    assign bus.BUSY = (state_q == COUNT);

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce: directed scenarios then random switch bouncing,
// checked against a history-window reference model and a load flip-flop.
`timescale 1ps/1ps
module tb_sw_debounce;

    localparam int  DB   = 4;
    localparam time STEP = 100000;

    logic CK = 1'b0;
    logic RB = 1'b0;
    logic q;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    bit   samp[$];
    bit   hist[$];
    logic m_dout = 1'b0;
    logic m_ld   = 1'b0;
    logic m_rise = 1'b0;
    logic m_fall = 1'b0;
    logic m_busy = 1'b0;
    logic m_q    = 1'bx;

    always #(STEP/2) CK = ~CK;

    sw_debounce_if bus ();

    sw_debounce #(.DB_CYCLES(DB), .CW(16)) dut (
        .CK  (CK),
        .RB  (RB),
        .bus (bus.slave)
    );

    // Downstream load flip-flop with its own reset and set tied inactive.
    always @(posedge CK) begin
        if (bus.LD) q <= bus.DOUT;
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // A change commits once the last DB synchronised samples all differ
    // from the current debounced level; s2 lags SW by two edges.
    task automatic model_edge(input logic sw, input logic rb);
        bit seen;
        int k;
        if (m_ld) m_q = m_dout;
        if (!rb) begin
            samp.delete();
            hist.delete();
            m_dout = 1'b0;
            m_ld   = 1'b0;
            m_rise = 1'b0;
            m_fall = 1'b0;
            m_busy = 1'b0;
        end else begin
            seen = (samp.size() >= 2) ? samp[samp.size()-2] : 1'b0;
            samp.push_back(sw);
            hist.push_back(seen);
            k = 0;
            for (int i = hist.size() - 1; i >= 0 && k < DB; i--) begin
                if (hist[i] == m_dout) break;
                k++;
            end
            if (k == DB) begin
                m_dout = seen;
                m_ld   = 1'b1;
                m_rise = seen;
                m_fall = ~seen;
                m_busy = 1'b0;
            end else begin
                m_ld   = 1'b0;
                m_rise = 1'b0;
                m_fall = 1'b0;
                m_busy = (k > 0);
            end
        end
    endtask

    task automatic step(input logic sw, input logic rb);
        @(negedge CK);
        #(STEP/4);
        bus.SW = sw;
        RB     = rb;
        @(posedge CK);
        model_edge(sw, rb);
        #1;
        check("dout", bus.DOUT, m_dout);
        check("ld",   bus.LD,   m_ld);
        check("rise", bus.RISE, m_rise);
        check("fall", bus.FALL, m_fall);
        check("busy", bus.BUSY, m_busy);
        check("q",    q,        m_q);
    endtask

    initial begin
        int   hold;
        logic rsw;
        logic rrb;
        bus.SW = 1'b0;

        // Reset held with switch high
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("rst_dout", bus.DOUT, 1'b0);
        check("rst_ld",   bus.LD,   1'b0);
        check("rst_busy", bus.BUSY, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b1);
            if (i == 5) check("rel_dout5", bus.DOUT, 1'b0);
            if (i == 6) check("rel_dout6", bus.DOUT, 1'b1);
        end

        // Clean fall
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1);
            if (i == 6) begin
                check("fall_dout", bus.DOUT, 1'b0);
                check("fall_strb", bus.FALL, 1'b1);
                check("fall_rise", bus.RISE, 1'b0);
            end
            if (i == 7) check("fall_end", bus.FALL, 1'b0);
        end

        // Clean rise
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b1);
            if (i == 2) check("rise_busy2", bus.BUSY, 1'b0);
            if (i == 3) check("rise_busy3", bus.BUSY, 1'b1);
            if (i == 6) begin
                check("rise_ld",   bus.LD,   1'b1);
                check("rise_strb", bus.RISE, 1'b1);
            end
            if (i == 7) begin
                check("rise_ld_end", bus.LD,   1'b0);
                check("rise_busy7",  bus.BUSY, 1'b0);
                check("rise_q",      q,        1'b1);
            end
        end

        for (int i = 1; i <= 8; i++) step(1'b0, 1'b1);

        // Glitch of three cycles is rejected
        for (int i = 1; i <= 9; i++) begin
            step((i <= 3) ? 1'b1 : 1'b0, 1'b1);
            if (i == 3) check("glitch_busy", bus.BUSY, 1'b1);
            if (i == 6) check("glitch_idle", bus.BUSY, 1'b0);
            check("glitch_dout", bus.DOUT, 1'b0);
            check("glitch_q",    q,        1'b0);
        end

        // Reset during a count
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b1);
        check("mid_busy", bus.BUSY, 1'b1);
        step(1'b1, 1'b0);
        check("mid_rst_busy", bus.BUSY, 1'b0);
        check("mid_rst_ld",   bus.LD,   1'b0);
        for (int i = 1; i <= 7; i++) begin
            step(1'b1, 1'b1);
            if (i == 5) check("mid_dout5", bus.DOUT, 1'b0);
            if (i == 6) check("mid_dout6", bus.DOUT, 1'b1);
            if (i == 6) check("mid_q6",    q,        1'b0);
            if (i == 7) check("mid_q7",    q,        1'b1);
        end

        // Random bouncing with occasional resets
        hold = 0;
        rsw  = 1'b1;
        for (int e = 0; e < 3000; e++) begin
            if (hold == 0) begin
                rsw  = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 8);
            end
            rrb = ($urandom_range(0, 199) != 0);
            step(rsw, rrb);
            hold--;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
